// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signal bundle for alu_cmd_issuer.
// slave is the issuer side, master is the stimulus/ALU/consumer side.
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [DATA_W-1:0] cmd_a_i;
    logic [DATA_W-1:0] cmd_b_i;
    logic [OP_W-1:0]   cmd_op_i;
    logic [DATA_W-1:0] alu_a_o;
    logic [DATA_W-1:0] alu_b_o;
    logic [OP_W-1:0]   alu_op_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;
    logic              alu_carry_i;
    logic              alu_error_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_result_o;
    logic [2:0]        rsp_flags_o;
    logic [CW-1:0]     count_o;

    modport slave (
        input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i,
        input  alu_result_i, alu_zero_i, alu_carry_i, alu_error_i,
        input  rsp_ready_i,
        output cmd_ready_o, alu_a_o, alu_b_o, alu_op_o,
        output rsp_valid_o, rsp_result_o, rsp_flags_o, count_o
    );

    modport master (
        output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i,
        output alu_result_i, alu_zero_i, alu_carry_i, alu_error_i,
        output rsp_ready_i,
        input  cmd_ready_o, alu_a_o, alu_b_o, alu_op_o,
        input  rsp_valid_o, rsp_result_o, rsp_flags_o, count_o
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command stage: FIFO-buffered commands issued one at a time,
// result captured after the ALU latency and held on a valid/ready response.
module alu_cmd_issuer #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    alu_cmd_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 * DATA_W + OP_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [2:0]        lat_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_result;
    logic [2:0]        rsp_flags;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Full blocks a push even when a pop frees a slot the same cycle.
    assign push  = bus.cmd_valid_i && !full;
    assign pop   = !empty &&
                   ((state == IDLE) ||
                    (state == RESP && bus.rsp_ready_i));

    assign bus.cmd_ready_o  = !full;
    assign bus.count_o      = count;
    assign bus.alu_a_o      = alu_a;
    assign bus.alu_b_o      = alu_b;
    assign bus.alu_op_o     = alu_op;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_result_o = rsp_result;
    assign bus.rsp_flags_o  = rsp_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.cmd_op_i, bus.cmd_b_i, bus.cmd_a_i};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (pop) begin
                {alu_op, alu_b, alu_a} <= mem[rd_ptr];
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= WAIT;
                        lat_cnt <= 3'(ALU_LAT);
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_result <= bus.alu_result_i;
                        rsp_flags  <= {bus.alu_error_i,
                                       bus.alu_carry_i,
                                       bus.alu_zero_i};
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        if (!empty) begin
                            state   <= WAIT;
                            lat_cnt <= 3'(ALU_LAT);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
